// File: rtl/instruction_decode.sv
// RV32I instruction-decode stage: register file, decoder, ID/EX register and load-use hazard detect.
// Optional macro ID_WB_BYPASS_EN forwards a same-cycle write-back to the register read ports.
module instruction_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instruction,
  input  logic        if_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [31:0] id_pc,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [3:0]  alu_op,
  output logic        alu_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        branch,
  output logic        jump,
  output logic        id_valid,
  output logic        illegal,
  output logic        hazard_stall
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLL    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_SLT    = 4'd8;
  localparam logic [3:0] ALU_SLTU   = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  typedef struct packed {
    logic [31:0] id_pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        branch;
    logic        jump;
    logic        id_valid;
    logic        illegal;
  } idex_t;

  logic [31:0] r_regs [32];
  idex_t       r_idex;
  idex_t       w_dec;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;

  logic [6:0] w_opcode;
  logic [4:0] w_rd_f;
  logic [2:0] w_f3;
  logic [4:0] w_rs1_f;
  logic [4:0] w_rs2_f;
  logic       w_f7b5;

  assign w_opcode = if_instruction[6:0];
  assign w_rd_f   = if_instruction[11:7];
  assign w_f3     = if_instruction[14:12];
  assign w_rs1_f  = if_instruction[19:15];
  assign w_rs2_f  = if_instruction[24:20];
  assign w_f7b5   = if_instruction[30];

  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
  assign w_imm_i = {{20{if_instruction[31]}}, if_instruction[31:20]};
  assign w_imm_s = {{20{if_instruction[31]}}, if_instruction[31:25], if_instruction[11:7]};
  assign w_imm_b = {{19{if_instruction[31]}}, if_instruction[31], if_instruction[7],
                    if_instruction[30:25], if_instruction[11:8], 1'b0};
  assign w_imm_j = {{11{if_instruction[31]}}, if_instruction[31], if_instruction[19:12],
                    if_instruction[20], if_instruction[30:21], 1'b0};
  assign w_imm_u = {if_instruction[31:12], 12'b0};

  // NOTE: the register array is reset like any other state because a cleared file is required after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (wb_en && (wb_rd != 5'd0)) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  logic w_wb_hit1, w_wb_hit2;
`ifdef ID_WB_BYPASS_EN
  assign w_wb_hit1 = wb_en && (wb_rd != 5'd0) && (wb_rd == w_rs1_f);
  assign w_wb_hit2 = wb_en && (wb_rd != 5'd0) && (wb_rd == w_rs2_f);
`else
  assign w_wb_hit1 = 1'b0;
  assign w_wb_hit2 = 1'b0;
`endif

  assign w_rs1_val = w_wb_hit1 ? wb_data : ((w_rs1_f == 5'd0) ? 32'd0 : r_regs[w_rs1_f]);
  assign w_rs2_val = w_wb_hit2 ? wb_data : ((w_rs2_f == 5'd0) ? 32'd0 : r_regs[w_rs2_f]);

  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic f7b5, input logic is_r);
    case (f3)
      3'b000:  alu_fn = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  endfunction

  // An illegal opcode decodes straight to a bubble carrying illegal=1.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_dec          = '0;
    w_use_rs1      = 1'b0;
    w_use_rs2      = 1'b0;
    w_dec.id_pc    = if_pc;
    w_dec.rs1_data = w_rs1_val;
    w_dec.rs2_data = w_rs2_val;
    w_dec.rs1      = w_rs1_f;
    w_dec.rs2      = w_rs2_f;
    w_dec.rd       = w_rd_f;
    w_dec.id_valid = 1'b1;
    w_dec.alu_op   = ALU_ADD;
    case (w_opcode)
      OP_R: begin
        w_dec.alu_op = alu_fn(w_f3, w_f7b5, 1'b1);
        w_dec.reg_write = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      OP_I_ALU: begin
        w_dec.alu_op = alu_fn(w_f3, w_f7b5, 1'b0);
        w_dec.imm = w_imm_i;
        w_dec.alu_src = 1'b1;
        w_dec.reg_write = 1'b1;
        w_use_rs1 = 1'b1;
      end
      OP_LOAD: begin
        w_dec.imm = w_imm_i;
        w_dec.alu_src = 1'b1;
        w_dec.mem_read = 1'b1;
        w_dec.mem_to_reg = 1'b1;
        w_dec.reg_write = 1'b1;
        w_use_rs1 = 1'b1;
      end
      OP_STORE: begin
        w_dec.imm = w_imm_s;
        w_dec.alu_src = 1'b1;
        w_dec.mem_write = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        w_dec.alu_op = ALU_SUB;
        w_dec.imm = w_imm_b;
        w_dec.branch = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      OP_JAL: begin
        w_dec.imm = w_imm_j;
        w_dec.alu_src = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.jump = 1'b1;
      end
      OP_JALR: begin
        w_dec.imm = w_imm_i;
        w_dec.alu_src = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.jump = 1'b1;
        w_use_rs1 = 1'b1;
      end
      OP_LUI: begin
        w_dec.alu_op = ALU_PASS_B;
        w_dec.imm = w_imm_u;
        w_dec.alu_src = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        w_dec.imm = w_imm_u;
        w_dec.alu_src = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      default: begin
        w_dec = '0;
        w_dec.illegal = 1'b1;
      end
    endcase
  end

  assign hazard_stall = r_idex.id_valid && r_idex.mem_read && (r_idex.rd != 5'd0) &&
                        if_valid && !flush &&
                        ((w_use_rs1 && (w_rs1_f == r_idex.rd)) ||
                         (w_use_rs2 && (w_rs2_f == r_idex.rd)));

  // NOTE: pipeline state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idex <= '0;
    end else if (flush) begin
      r_idex <= '0;
    end else if (stall) begin
      r_idex <= r_idex;
    end else if (hazard_stall || !if_valid) begin
      r_idex <= '0;
    end else begin
      r_idex <= w_dec;
    end
  end

  assign id_pc      = r_idex.id_pc;
  assign rs1_data   = r_idex.rs1_data;
  assign rs2_data   = r_idex.rs2_data;
  assign imm        = r_idex.imm;
  assign rs1        = r_idex.rs1;
  assign rs2        = r_idex.rs2;
  assign rd         = r_idex.rd;
  assign alu_op     = r_idex.alu_op;
  assign alu_src    = r_idex.alu_src;
  assign mem_read   = r_idex.mem_read;
  assign mem_write  = r_idex.mem_write;
  assign reg_write  = r_idex.reg_write;
  assign mem_to_reg = r_idex.mem_to_reg;
  assign branch     = r_idex.branch;
  assign jump       = r_idex.jump;
  assign id_valid   = r_idex.id_valid;
  assign illegal    = r_idex.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: decode vector table plus hazard/stall/flush/reset sequences.
module tb_instruction_decode;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic        if_valid;
  logic        stall;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] id_pc, rs1_data, rs2_data, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_op;
  logic        alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump;
  logic        id_valid, illegal, hazard_stall;

  instruction_decode dut (
    .clk(clk), .rst(rst),
    .if_pc(if_pc), .if_instruction(if_instruction), .if_valid(if_valid),
    .stall(stall), .flush(flush),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .id_pc(id_pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd), .alu_op(alu_op),
    .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .branch(branch), .jump(jump),
    .id_valid(id_valid), .illegal(illegal), .hazard_stall(hazard_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump, illegal}
  logic [7:0] ctrl_o;
  assign ctrl_o = {alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump, illegal};

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [3:0]  op;
    logic [7:0]  ctrl;
    logic        valid;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] LW_X11  = 32'h00012583;
  localparam logic [31:0] ADD_X12 = 32'h00B58633;
  localparam logic [31:0] ADDI_X1 = 32'h00500093;
  localparam logic [31:0] ADDI_X4 = 32'h00018213;

`ifdef ID_WB_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'h0000000F;
`else
  localparam logic [31:0] BYP_EXP = 32'h00000000;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic v);
    if_instruction = inst;
    if_pc = pc;
    if_valid = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs [15];

  initial begin
    vecs[0]  = '{32'h00500093, 5'd1,  5'd0,  5'd5,  32'h00000005, 4'd0,  8'b1001_0000, 1'b1};
    vecs[1]  = '{32'h00B58633, 5'd12, 5'd11, 5'd11, 32'h00000000, 4'd0,  8'b0001_0000, 1'b1};
    vecs[2]  = '{32'h402081B3, 5'd3,  5'd1,  5'd2,  32'h00000000, 4'd1,  8'b0001_0000, 1'b1};
    vecs[3]  = '{32'h407352B3, 5'd5,  5'd6,  5'd7,  32'h00000000, 4'd7,  8'b0001_0000, 1'b1};
    vecs[4]  = '{32'h00012583, 5'd11, 5'd2,  5'd0,  32'h00000000, 4'd0,  8'b1101_1000, 1'b1};
    vecs[5]  = '{32'hFE512E23, 5'd28, 5'd2,  5'd5,  32'hFFFFFFFC, 4'd0,  8'b1010_0000, 1'b1};
    vecs[6]  = '{32'hFE208CE3, 5'd25, 5'd1,  5'd2,  32'hFFFFFFF8, 4'd1,  8'b0000_0100, 1'b1};
    vecs[7]  = '{32'h008000EF, 5'd1,  5'd0,  5'd8,  32'h00000008, 4'd0,  8'b1001_0010, 1'b1};
    vecs[8]  = '{32'h00C08067, 5'd0,  5'd1,  5'd12, 32'h0000000C, 4'd0,  8'b1001_0010, 1'b1};
    vecs[9]  = '{32'h123452B7, 5'd5,  5'd8,  5'd3,  32'h12345000, 4'd10, 8'b1001_0000, 1'b1};
    vecs[10] = '{32'hFFFFF317, 5'd6,  5'd31, 5'd31, 32'hFFFFF000, 4'd0,  8'b1001_0000, 1'b1};
    vecs[11] = '{32'hFFF0C393, 5'd7,  5'd1,  5'd31, 32'hFFFFFFFF, 4'd4,  8'b1001_0000, 1'b1};
    vecs[12] = '{32'h4034D413, 5'd8,  5'd9,  5'd3,  32'h00000403, 4'd7,  8'b1001_0000, 1'b1};
    vecs[13] = '{32'h0000007F, 5'd0,  5'd0,  5'd0,  32'h00000000, 4'd0,  8'b0000_0001, 1'b0};
    vecs[14] = '{32'h0020B533, 5'd10, 5'd1,  5'd2,  32'h00000000, 4'd9,  8'b0001_0000, 1'b1};

    rst = 1'b1;
    stall = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    drive(ADDI_X1, 32'h0000_0100, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("reset id_valid", 32'(id_valid), 32'd0);
    check("reset ctrl", 32'(ctrl_o), 32'd0);
    check("reset rd", 32'(rd), 32'd0);
    check("reset hazard", 32'(hazard_stall), 32'd0);
    check("reset id_pc", id_pc, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].inst, 32'h1000 + 32'(i) * 4, 1'b1);
      tick();
      check($sformatf("v%0d id_valid", i), 32'(id_valid), 32'(vecs[i].valid));
      check($sformatf("v%0d rd", i), 32'(rd), 32'(vecs[i].rd));
      check($sformatf("v%0d rs1", i), 32'(rs1), 32'(vecs[i].rs1));
      check($sformatf("v%0d rs2", i), 32'(rs2), 32'(vecs[i].rs2));
      check($sformatf("v%0d imm", i), imm, vecs[i].imm);
      check($sformatf("v%0d alu_op", i), 32'(alu_op), 32'(vecs[i].op));
      check($sformatf("v%0d ctrl", i), 32'(ctrl_o), 32'(vecs[i].ctrl));
      if (vecs[i].valid)
        check($sformatf("v%0d id_pc", i), id_pc, 32'h1000 + 32'(i) * 4);
    end

    // same-cycle write-back to x3 while reading it
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000000F;
    drive(ADDI_X4, 32'h2000, 1'b1);
    tick();
    check("bypass rs1_data", rs1_data, BYP_EXP);
    wb_en = 1'b0;
    tick();
    check("written x3 rs1_data", rs1_data, 32'h0000000F);

    // x0 is never written
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
    drive(ADDI_X1, 32'h2004, 1'b1);
    tick();
    wb_en = 1'b0;
    tick();
    check("x0 rs1_data", rs1_data, 32'd0);

    // load-use: bubble then issue
    drive(LW_X11, 32'h3000, 1'b1);
    tick();
    check("lu load mem_read", 32'(mem_read), 32'd1);
    drive(ADD_X12, 32'h3004, 1'b1);
    #1;
    check("lu hazard", 32'(hazard_stall), 32'd1);
    tick();
    check("lu bubble id_valid", 32'(id_valid), 32'd0);
    check("lu bubble rd", 32'(rd), 32'd0);
    check("lu hazard cleared", 32'(hazard_stall), 32'd0);
    tick();
    check("lu add id_valid", 32'(id_valid), 32'd1);
    check("lu add rd", 32'(rd), 32'd12);
    check("lu add pc", id_pc, 32'h3004);

    // stall together with hazard holds the load in ID/EX
    drive(LW_X11, 32'h3100, 1'b1);
    tick();
    drive(ADD_X12, 32'h3104, 1'b1);
    stall = 1'b1;
    tick();
    check("sh hold id_valid", 32'(id_valid), 32'd1);
    check("sh hold rd", 32'(rd), 32'd11);
    check("sh hold mem_read", 32'(mem_read), 32'd1);
    check("sh hazard kept", 32'(hazard_stall), 32'd1);
    stall = 1'b0;
    tick();
    check("sh bubble id_valid", 32'(id_valid), 32'd0);
    tick();
    check("sh add rd", 32'(rd), 32'd12);

    // rs2 field matches the load rd but I-ALU does not use rs2
    drive(LW_X11, 32'h3200, 1'b1);
    tick();
    drive(32'h00B10093, 32'h3204, 1'b1);
    #1;
    check("unused rs2 hazard", 32'(hazard_stall), 32'd0);
    tick();
    check("unused rs2 issue", 32'(id_valid), 32'd1);

    // flush masks the hazard
    drive(LW_X11, 32'h3300, 1'b1);
    tick();
    drive(ADD_X12, 32'h3304, 1'b1);
    flush = 1'b1;
    #1;
    check("flush masks hazard", 32'(hazard_stall), 32'd0);
    tick();
    check("flush bubble id_valid", 32'(id_valid), 32'd0);
    flush = 1'b0;

    // flush beats stall
    drive(ADDI_X1, 32'h3400, 1'b1);
    tick();
    check("fs pre id_valid", 32'(id_valid), 32'd1);
    flush = 1'b1; stall = 1'b1;
    tick();
    check("fs id_valid", 32'(id_valid), 32'd0);
    check("fs ctrl", 32'(ctrl_o), 32'd0);
    check("fs rd", 32'(rd), 32'd0);
    flush = 1'b0; stall = 1'b0;

    // plain stall holds outputs
    drive(ADDI_X1, 32'h3500, 1'b1);
    tick();
    drive(32'h402081B3, 32'h3504, 1'b1);
    stall = 1'b1;
    tick();
    check("stall hold pc", id_pc, 32'h3500);
    check("stall hold rd", 32'(rd), 32'd1);
    stall = 1'b0;

    // if_valid=0 gives a bubble
    drive(ADDI_X1, 32'h3600, 1'b0);
    tick();
    check("novalid id_valid", 32'(id_valid), 32'd0);
    check("novalid reg_write", 32'(reg_write), 32'd0);

    // asynchronous reset mid-operation
    drive(ADDI_X1, 32'h3700, 1'b1);
    tick();
    check("pre-rst id_valid", 32'(id_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst id_valid", 32'(id_valid), 32'd0);
    check("async rst rd", 32'(rd), 32'd0);
    tick();
    rst = 1'b0;
    drive(ADDI_X4, 32'h3800, 1'b1);
    tick();
    check("post-rst id_valid", 32'(id_valid), 32'd1);
    check("post-rst rd", 32'(rd), 32'd4);
    check("post-rst x3 cleared", rs1_data, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
